// File: rtl/chess_pkg.sv
// chess_pkg
//   Shared definitions for the board evaluator and the move generators:
//   piece kind codes, colour constants and the material weight table.
//   A piece is stored as a signed byte: the sign gives the colour
//   (+ white, - black, 0 empty) and the magnitude gives the kind.
package chess_pkg;

  // Piece kinds by magnitude of the signed piece byte
  typedef enum logic [2:0] {
    PC_NONE   = 3'd0,
    PC_PAWN   = 3'd1,
    PC_KNIGHT = 3'd2,
    PC_BISHOP = 3'd3,
    PC_ROOK   = 3'd4,
    PC_QUEEN  = 3'd5,
    PC_KING   = 3'd6
  } piece_kind_t;

  // Colour constants as they appear in the sign of a piece byte
  localparam logic signed [7:0] WHITE = 8'sd1;
  localparam logic signed [7:0] BLACK = -8'sd1;
  localparam logic signed [7:0] EMPTY = 8'sd0;

  // Material weights, indexed by piece kind
  localparam logic [7:0] W_PAWN   = 8'd1;
  localparam logic [7:0] W_KNIGHT = 8'd3;
  localparam logic [7:0] W_BISHOP = 8'd3;
  localparam logic [7:0] W_ROOK   = 8'd5;
  localparam logic [7:0] W_QUEEN  = 8'd9;
  localparam logic [7:0] W_KING   = 8'd100;

  // Weight of a piece magnitude; anything outside 1..6 is worth nothing
  function automatic logic [7:0] piece_weight(input logic [7:0] mag);
    logic [7:0] w;
    w = 8'd0;
    case (mag)
      8'(PC_PAWN):   w = W_PAWN;
      8'(PC_KNIGHT): w = W_KNIGHT;
      8'(PC_BISHOP): w = W_BISHOP;
      8'(PC_ROOK):   w = W_ROOK;
      8'(PC_QUEEN):  w = W_QUEEN;
      8'(PC_KING):   w = W_KING;
      default:       w = 8'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/piece_value.sv
// piece_value
//   Combinational material value of one square.
//   Ports:
//     piece - signed piece byte (sign = colour, magnitude = kind)
//     value - signed weighted value, positive for white, negative for black
module piece_value
  import chess_pkg::*;
(
  input  logic        [7:0] piece,
  output logic signed [7:0] value
);

  logic [7:0] mag;
  logic [7:0] weight;

  // Magnitude of -128 is 128, which falls outside the table and weighs 0
  always_comb begin
    mag    = piece[7] ? (~piece + 8'd1) : piece;
    weight = piece_weight(mag);
    value  = piece[7] ? -$signed(weight) : $signed(weight);
  end

endmodule

// File: rtl/board_eval.sv
// board_eval
//   Scores a run of 64-word boards produced by the move generator and
//   reports the index and effective score of the best one.
//   Ports:
//     clk, rst              - clock, synchronous active-high reset
//     slave_*               - CPU register port: 1 src, 2 n_boards, 3 side,
//                             write 0 starts; read 0 best_idx, 1 best score
//     master_*              - read-only SDRAM master, one read in flight
module board_eval
  import chess_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {
    IDLE, ARGS, RD_REQ, RD_WAIT, ACCUM, NEXT_BOARD, DONE
  } state_t;

  localparam logic signed [15:0] BEST_INIT = 16'sh8000;

  state_t             state, state_next;
  logic [31:0]        src_addr;
  logic [7:0]         n_boards;
  logic               side_black;
  logic [3:0]         cmd_addr;
  logic [31:0]        cmd_data;
  logic [5:0]         square;
  logic [7:0]         board_idx;
  logic signed [15:0] accum;
  logic signed [15:0] best_score;
  logic [31:0]        best_idx;
  logic [7:0]         piece;
  logic signed [7:0]  piece_val;
  logic signed [15:0] eff_score;
  logic               last_board;
  logic               unused_readdata;

  piece_value u_piece_value (
    .piece (piece),
    .value (piece_val)
  );

  assign eff_score       = side_black ? -accum : accum;
  assign last_board      = (board_idx == (n_boards - 8'd1));
  assign unused_readdata = ^master_readdata[31:8];

  // Writes are only taken while idle or done; every other state stalls the CPU.
  // Reset also holds the stall and kills any read request combinationally.
  assign slave_waitrequest = rst || !((state == IDLE) || (state == DONE));
  assign master_read       = !rst && (state == RD_REQ);
  assign master_write      = 1'b0;
  assign master_writedata  = '0;

  // Read mux for results; unknown addresses read as zero
  always_comb begin
    slave_readdata = '0;
    case (slave_address)
      4'd0:    slave_readdata = best_idx;
      4'd1:    slave_readdata = {{16{best_score[15]}}, best_score};
      default: slave_readdata = '0;
    endcase
  end

  // Datapath and state register. The SDRAM address simply walks forward by one
  // word per square, since the boards are contiguous, so it stays stable while
  // a request waits and needs no multiply. The square counter wraps to 0 on
  // its own after square 63.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      src_addr       <= '0;
      n_boards       <= '0;
      side_black     <= 1'b0;
      cmd_addr       <= '0;
      cmd_data       <= '0;
      square         <= '0;
      board_idx      <= '0;
      accum          <= '0;
      best_score     <= BEST_INIT;
      best_idx       <= '1;
      piece          <= '0;
      master_address <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (slave_write) begin
            cmd_addr <= slave_address;
            cmd_data <= slave_writedata;
          end
        end
        ARGS: begin
          case (cmd_addr)
            4'd0: begin
              square         <= '0;
              board_idx      <= '0;
              accum          <= '0;
              best_score     <= BEST_INIT;
              best_idx       <= '1;
              master_address <= src_addr;
            end
            4'd1:    src_addr   <= cmd_data;
            4'd2:    n_boards   <= cmd_data[7:0];
            4'd3:    side_black <= (cmd_data == 32'hFFFF_FFFF);
            default: ;
          endcase
        end
        RD_WAIT: begin
          if (master_readdatavalid) piece <= master_readdata[7:0];
        end
        ACCUM: begin
          accum          <= accum + {{8{piece_val[7]}}, piece_val};
          square         <= square + 6'd1;
          master_address <= master_address + 32'd4;
        end
        NEXT_BOARD: begin
          if (eff_score > best_score) begin
            best_score <= eff_score;
            best_idx   <= {24'd0, board_idx};
          end
          accum     <= '0;
          board_idx <= board_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; strict greater-than in NEXT_BOARD keeps the lower index on ties
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (slave_write) state_next = ARGS;
      ARGS: begin
        if (cmd_addr == 4'd0) state_next = (n_boards == 8'd0) ? DONE : RD_REQ;
        else                  state_next = IDLE;
      end
      RD_REQ:     if (!master_waitrequest) state_next = RD_WAIT;
      RD_WAIT:    if (master_readdatavalid) state_next = ACCUM;
      ACCUM:      state_next = (square == 6'd63) ? NEXT_BOARD : RD_REQ;
      NEXT_BOARD: state_next = last_board ? DONE : RD_REQ;
      DONE: begin
        if (slave_write)                               state_next = ARGS;
        else if (slave_read && slave_address == 4'd0) state_next = IDLE;
      end
      default:    state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_board_eval.sv
// tb_board_eval
//   Self-checking bench for board_eval: an SDRAM responder model with
//   optional random stalls, a table of single-board material vectors and
//   hand-written multi-board, busy-write and mid-run reset sequences.
module tb_board_eval;

  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int          MEM_WORDS = 1024;
  localparam int          TIMEOUT   = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  logic [31:0] mem [MEM_WORDS];
  int          compared     = 0;
  int          mismatched   = 0;
  int          overlapCount = 0;
  int          addrErrors   = 0;
  int          countdown    = -1;
  logic [31:0] respAddr     = '0;
  bit          stallMode    = 1'b0;

  typedef struct {
    logic [7:0]         piece;
    logic [31:0]        side;
    logic signed [15:0] expScore;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  board_eval dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  // SDRAM responder: decides waitrequest for the coming edge, then notes an
  // accepted read and returns its data 0..5 cycles later in stall mode
  initial begin
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      if (countdown == 0) begin
        if (respAddr < BASE || ((respAddr - BASE) >> 2) >= MEM_WORDS) begin
          addrErrors++;
          master_readdata = '0;
        end else begin
          master_readdata = mem[(respAddr - BASE) >> 2];
        end
        master_readdatavalid = 1'b1;
        countdown = -1;
      end else if (countdown > 0) begin
        countdown--;
      end
      master_waitrequest = stallMode ? ($urandom_range(0, 2) == 0) : 1'b0;
      #1;
      if (master_read && !master_waitrequest) begin
        if (countdown != -1) overlapCount++;
        countdown = stallMode ? int'($urandom_range(0, 5)) : 0;
        respAddr  = master_address;
      end
    end
  end

  function automatic logic [31:0] sq(input logic signed [7:0] p);
    return {24'hA5C35A, p};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic loadInitial(input int slot);
    logic signed [7:0] back [8];
    back = '{8'sd4, 8'sd2, 8'sd3, 8'sd5, 8'sd6, 8'sd3, 8'sd2, 8'sd4};
    for (int k = 0; k < 64; k++) mem[slot*64 + k] = sq(8'sd0);
    for (int f = 0; f < 8; f++) begin
      mem[slot*64 + f]      = sq(back[f]);
      mem[slot*64 + 8 + f]  = sq(8'sd1);
      mem[slot*64 + 48 + f] = sq(-8'sd1);
      mem[slot*64 + 56 + f] = sq(-back[f]);
    end
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    #1;
    while (slave_waitrequest) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > TIMEOUT) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL write_timeout: waitrequest still %b, expected 0", slave_waitrequest);
        break;
      end
    end
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_read    = 1'b1;
    #1;
    d = slave_readdata;
    @(negedge clk);
    slave_read = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (!slave_waitrequest) break;
      if (cycles > TIMEOUT) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL done_timeout: busy after %0d cycles, expected DONE", cycles);
        break;
      end
    end
  endtask

  task automatic startRun(input int slot, input int n, input logic [31:0] side);
    busWrite(4'd1, BASE + 32'(slot * 256));
    busWrite(4'd2, 32'(n));
    busWrite(4'd3, side);
    busWrite(4'd0, 32'd0);
  endtask

  task automatic applyStimulus(input int slot, input int n, input logic [31:0] side,
                               output logic [31:0] idx, output logic [31:0] score,
                               output int cycles);
    startRun(slot, n, side);
    waitDone(cycles);
    busRead(4'd1, score);
    busRead(4'd0, idx);
  endtask

  initial begin
    logic [31:0]        idx, score, rd;
    logic signed [31:0] exp32;
    int                 cyc;

    rst             = 1'b1;
    slave_address   = '0;
    slave_read      = 1'b0;
    slave_write     = 1'b0;
    slave_writedata = '0;

    for (int k = 0; k < MEM_WORDS; k++) mem[k] = '0;
    loadInitial(0);
    loadInitial(1);
    loadInitial(2);
    mem[2*64 + 56] = sq(8'sd0);
    loadInitial(3);
    mem[3*64 + 63] = sq(8'sd0);

    vecs[0]  = '{8'h01, 32'd1,          16'sd8};
    vecs[1]  = '{8'h02, 32'd1,          16'sd24};
    vecs[2]  = '{8'h03, 32'd1,          16'sd24};
    vecs[3]  = '{8'h04, 32'd1,          16'sd40};
    vecs[4]  = '{8'h05, 32'd1,          16'sd72};
    vecs[5]  = '{8'h06, 32'd1,          16'sd800};
    vecs[6]  = '{8'hFF, 32'd1,          -16'sd8};
    vecs[7]  = '{8'hFA, 32'd1,          -16'sd800};
    vecs[8]  = '{8'h07, 32'd1,          16'sd0};
    vecs[9]  = '{8'h80, 32'd1,          16'sd0};
    vecs[10] = '{8'hF9, 32'd1,          16'sd0};
    vecs[11] = '{8'hFB, 32'hFFFF_FFFF,  16'sd72};
    vecs[12] = '{8'h04, 32'd2,          16'sd40};
    vecs[13] = '{8'h04, 32'hFFFF_FFFF, -16'sd40};

    $display("[TB] reset checks");
    repeat (3) @(negedge clk);
    checkOutput("rst_waitrequest", {31'd0, slave_waitrequest}, 32'd1);
    checkOutput("rst_master_read", {31'd0, master_read}, 32'd0);
    checkOutput("rst_master_write", {31'd0, master_write}, 32'd0);
    checkOutput("rst_master_address", master_address, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
    busRead(4'd0, rd);
    checkOutput("rst_best_idx", rd, 32'hFFFF_FFFF);

    $display("[TB] initial position");
    applyStimulus(0, 1, 32'd1, idx, score, cyc);
    checkOutput("initial_idx", idx, 32'd0);
    checkOutput("initial_score", score, 32'd0);
    checkOutput("latency_one_board", {31'd0, (cyc >= 193 && cyc <= 196)}, 32'd1);

    $display("[TB] three boards");
    applyStimulus(1, 3, 32'd1, idx, score, cyc);
    checkOutput("three_white_idx", idx, 32'd1);
    checkOutput("three_white_score", score, 32'd5);
    applyStimulus(1, 3, 32'hFFFF_FFFF, idx, score, cyc);
    checkOutput("three_black_idx", idx, 32'd0);
    checkOutput("three_black_score", score, 32'd0);

    $display("[TB] zero boards");
    applyStimulus(1, 0, 32'd1, idx, score, cyc);
    checkOutput("zero_done_cycles", {31'd0, (cyc <= 3)}, 32'd1);
    checkOutput("zero_idx", idx, 32'hFFFF_FFFF);

    $display("[TB] piece table");
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 64; k++) mem[10*64 + k] = sq((k < 8) ? vecs[i].piece : 8'h00);
      applyStimulus(10, 1, vecs[i].side, idx, score, cyc);
      exp32 = vecs[i].expScore;
      checkOutput($sformatf("vec%0d_score", i), score, exp32);
      checkOutput($sformatf("vec%0d_idx", i), idx, 32'd0);
    end

    $display("[TB] write while busy");
    startRun(1, 3, 32'd1);
    repeat (40) @(negedge clk);
    slave_address   = 4'd2;
    slave_writedata = 32'd0;
    slave_write     = 1'b1;
    repeat (4) @(negedge clk);
    slave_write = 1'b0;
    waitDone(cyc);
    busRead(4'd1, score);
    busRead(4'd0, idx);
    checkOutput("busy_write_idx", idx, 32'd1);
    checkOutput("busy_write_score", score, 32'd5);

    $display("[TB] stalled memory");
    stallMode = 1'b1;
    applyStimulus(1, 3, 32'd1, idx, score, cyc);
    checkOutput("stall_white_idx", idx, 32'd1);
    checkOutput("stall_white_score", score, 32'd5);
    applyStimulus(1, 3, 32'hFFFF_FFFF, idx, score, cyc);
    checkOutput("stall_black_idx", idx, 32'd0);
    checkOutput("stall_black_score", score, 32'd0);
    applyStimulus(0, 1, 32'd1, idx, score, cyc);
    checkOutput("stall_initial_score", score, 32'd0);

    $display("[TB] reset mid-board");
    startRun(1, 3, 32'd1);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_waitrequest", {31'd0, slave_waitrequest}, 32'd1);
    checkOutput("mid_rst_master_read", {31'd0, master_read}, 32'd0);
    checkOutput("mid_rst_master_address", master_address, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("mid_post_rst_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
    repeat (10) @(negedge clk);
    busRead(4'd0, rd);
    checkOutput("mid_rst_best_idx", rd, 32'hFFFF_FFFF);
    applyStimulus(1, 3, 32'd1, idx, score, cyc);
    checkOutput("restart_idx", idx, 32'd1);
    checkOutput("restart_score", score, 32'd5);
    stallMode = 1'b0;

    checkOutput("overlapping_reads", 32'(overlapCount), 32'd0);
    checkOutput("bad_read_addresses", 32'(addrErrors), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
